// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Bridges the core's memory-stage request to a word-addressed data memory that
// has a combinational 32-bit read, a synchronous write and no byte enables.
// Loads do lane extraction with sign/zero extension. SW is a single write.
// SB/SH are done as a read-modify-write: the word is read, the target lane is
// replaced, then the merged word is written back. Misaligned accesses and
// illegal funct3 codes are answered with an error response in the same edge
// that accepts the request, and no memory write is issued for them.
//
// Ports:
//   clk         clock, all state updates on posedge
//   rst         asynchronous active-low reset
//   req_valid   core presents a request
//   req_ready   unit is idle and accepts a request this cycle
//   req_we      1 = store, 0 = load
//   req_funct3  RISC-V funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
//   req_addr    byte address
//   req_wdata   store data (low bits used for B/H)
//   rsp_valid   one-cycle response pulse
//   rsp_rdata   extended load data, 0 for stores and errors
//   rsp_err     misaligned or illegal access, valid with rsp_valid
//   mem_we      data memory write enable
//   mem_addr    word-aligned memory address
//   mem_wd      data memory write data
//   mem_rd      data memory combinational read data
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // only 32 is supported
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wd,
    input  logic [DATA_W-1:0] mem_rd
);

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        READ  = 2'd2,
        WRITE = 2'd3
    } state_t;

    state_t      state;
    logic [2:0]  lat_funct3;
    logic [1:0]  lat_off;
    logic [15:0] lat_wdata;   // only the B/H lanes are needed for the merge

    // Misaligned or illegal request, decided from the raw request fields.
    function automatic logic req_error(input logic       we,
                                       input logic [2:0] f3,
                                       input logic [1:0] off);
        logic bad;
        // NOTE: every path of a combinational function/block assigns a
        // default first, so no latch-like "hold" behaviour is implied.
        bad = 1'b0;
        case (f3)
            F3_B:    bad = 1'b0;
            F3_H:    bad = off[0];
            F3_W:    bad = (off != 2'b00);
            F3_BU:   bad = we;
            F3_HU:   bad = we | off[0];
            default: bad = 1'b1;   // 011, 110, 111
        endcase
        return bad;
    endfunction

    // Pick the addressed lane out of a memory word and extend it.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [2:0]  f3,
                                                 input logic [1:0]  off);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'h00;
        h = 16'h0000;
        r = 32'h0;
        case (off)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = off[1] ? word[31:16] : word[15:0];
        case (f3)
            F3_B:    r = {{24{b[7]}}, b};
            F3_H:    r = {{16{h[15]}}, h};
            F3_BU:   r = {24'h0, b};
            F3_HU:   r = {16'h0, h};
            default: r = word;   // W; errors never reach LOAD
        endcase
        return r;
    endfunction

    // Replace the target lane of the old word with the store data.
    function automatic logic [31:0] store_merge(input logic [31:0] word,
                                                input logic [15:0] wd,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        if (f3 == F3_H) begin
            if (off[1]) r[31:16] = wd;
            else        r[15:0]  = wd;
        end else begin
            case (off)
                2'd0:    r[7:0]   = wd[7:0];
                2'd1:    r[15:8]  = wd[7:0];
                2'd2:    r[23:16] = wd[7:0];
                default: r[31:24] = wd[7:0];
            endcase
        end
        return r;
    endfunction

    assign req_ready = (state == IDLE);

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            lat_funct3 <= 3'b000;
            lat_off    <= 2'b00;
            lat_wdata  <= 16'h0;
            rsp_valid  <= 1'b0;
            rsp_err    <= 1'b0;
            rsp_rdata  <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
        end else begin
            // Response outputs are single-cycle pulses unless set below.
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= '0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (req_error(req_we, req_funct3, req_addr[1:0])) begin
                            // Answered immediately; the unit stays idle.
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else begin
                            lat_funct3 <= req_funct3;
                            lat_off    <= req_addr[1:0];
                            lat_wdata  <= req_wdata[15:0];
                            mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
                            if (!req_we) begin
                                state <= LOAD;
                            end else if (req_funct3 == F3_W) begin
                                // Full word: no need to read the old contents.
                                mem_wd <= req_wdata;
                                mem_we <= 1'b1;
                                state  <= WRITE;
                            end else begin
                                state <= READ;
                            end
                        end
                    end
                end
                LOAD: begin
                    rsp_rdata <= load_extract(mem_rd, lat_funct3, lat_off);
                    rsp_valid <= 1'b1;
                    mem_addr  <= '0;
                    state     <= IDLE;
                end
                READ: begin
                    // mem_wd doubles as the merge register for sub-word stores.
                    mem_wd <= store_merge(mem_rd, lat_wdata, lat_funct3, lat_off);
                    mem_we <= 1'b1;
                    state  <= WRITE;
                end
                default: begin   // WRITE: memory commits on this edge
                    mem_we    <= 1'b0;
                    mem_wd    <= '0;
                    mem_addr  <= '0;
                    rsp_valid <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
//
// Drives load_store_unit against a 64-word behavioural data memory. Expected
// results come from a reference model that works on whole words with shifts
// and masks, plus a shadow copy of memory updated by the model.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    always #5 clk = ~clk;

    load_store_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wd     (mem_wd),
        .mem_rd     (mem_rd)
    );

    // Data memory: combinational read, posedge write, backdoor port for setup.
    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    logic        bd_we   = 1'b0;
    logic [5:0]  bd_idx  = '0;
    logic [31:0] bd_data = '0;
    logic [31:0] last_wd = '0;
    int          we_cycles = 0;

    assign mem_rd = mem[mem_addr[7:2]];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr[7:2]] <= mem_wd;
            last_wd            <= mem_wd;
            we_cycles          <= we_cycles + 1;
        end else if (bd_we) begin
            mem[bd_idx] <= bd_data;
        end
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    endtask

    // ---------------- reference model ----------------
    function automatic logic ref_err(input logic we, input logic [2:0] f3, input logic [31:0] a);
        logic illegal, misaligned;
        illegal    = (f3 == 3) || (f3 == 6) || (f3 == 7) || (we && (f3 == 4 || f3 == 5));
        misaligned = ((f3 == 1 || f3 == 5) && a[0]) || (f3 == 2 && a[1:0] != 0);
        return illegal || misaligned;
    endfunction

    function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] b, h;
        b = (w >> (8 * a[1:0])) & 32'hFF;
        h = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0:    return b[7]  ? (b | 32'hFFFF_FF00) : b;
            3'd1:    return h[15] ? (h | 32'hFFFF_0000) : h;
            3'd4:    return b;
            3'd5:    return h;
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [31:0] w, input logic [31:0] wd,
                                              input logic [2:0] f3, input logic [31:0] a);
        logic [31:0] mask, data;
        case (f3)
            3'd0: begin mask = 32'hFF   << (8 * a[1:0]); data = wd << (8 * a[1:0]); end
            3'd1: begin mask = 32'hFFFF << (16 * a[1]);  data = wd << (16 * a[1]);  end
            default: begin mask = 32'hFFFF_FFFF; data = wd; end
        endcase
        return (w & ~mask) | (data & mask);
    endfunction

    // ---------------- stimulus helpers ----------------
    task automatic poke(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_we = 1'b1; bd_idx = a[7:2]; bd_data = d;
        @(posedge clk); #1;
        bd_we = 1'b0;
        ref_mem[a[7:2]] = d;
    endtask

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        logic        e;
        logic [31:0] old_w, exp_rd, exp_w;
        int          exp_lat, lat, we0;
        old_w   = ref_mem[a[7:2]];
        e       = ref_err(we, f3, a);
        exp_rd  = (e || we) ? 32'h0 : ref_load(old_w, f3, a);
        exp_w   = ref_store(old_w, wd, f3, a);
        exp_lat = e ? 0 : (!we ? 1 : (f3 == 3'd2 ? 1 : 2));
        @(negedge clk);
        check("ready_before", {31'h0, req_ready}, 32'h1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
        we0 = we_cycles;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0;
        while (!rsp_valid && lat < 6) begin
            @(posedge clk); #1;
            lat++;
        end
        check("latency", lat, exp_lat);
        check("rsp_err", {31'h0, rsp_err}, {31'h0, e});
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("write_cycles", we_cycles - we0, (we && !e) ? 1 : 0);
        check("ready_with_rsp", {31'h0, req_ready}, 32'h1);
        if (we && !e) begin
            check("mem_wd", last_wd, exp_w);
            ref_mem[a[7:2]] = exp_w;
        end
        @(posedge clk); #1;
        check("rsp_pulse", {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        int we_snap;
        rst = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = '0; req_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("rst_mem_we", {31'h0, mem_we}, 32'h0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check("rst_mem_wd", mem_wd, 32'h0);
        check("rst_rdata", rsp_rdata, 32'h0);
        @(negedge clk); rst = 1'b1;

        for (int i = 0; i < 64; i++) poke(i * 4, $urandom);

        // Word load
        poke(32'h10, 32'h8899AABB);
        do_req(1'b0, 3'd2, 32'h10, 32'h0);

        // Sub-word loads with sign/zero extension
        poke(32'h10, 32'h80112233);
        do_req(1'b0, 3'd0, 32'h13, 32'h0);
        check("lb_0x13", rsp_rdata, 32'h0);   // pulse already gone
        do_req(1'b0, 3'd4, 32'h13, 32'h0);
        do_req(1'b0, 3'd1, 32'h12, 32'h0);
        do_req(1'b0, 3'd5, 32'h12, 32'h0);
        do_req(1'b0, 3'd0, 32'h10, 32'h0);

        // Sub-word and word stores
        poke(32'h20, 32'h11223344);
        do_req(1'b1, 3'd0, 32'h21, 32'hFFFFFFAB);
        check("sb_result", mem[8], 32'h1122AB44);
        do_req(1'b0, 3'd2, 32'h20, 32'h0);
        poke(32'h20, 32'h11223344);
        do_req(1'b1, 3'd1, 32'h22, 32'h0000BEEF);
        check("sh_result", mem[8], 32'hBEEF3344);
        do_req(1'b1, 3'd2, 32'h24, 32'hDEADBEEF);
        check("sw_result", mem[9], 32'hDEADBEEF);

        // Errors, back to back
        do_req(1'b0, 3'd2, 32'h06, 32'h0);
        do_req(1'b1, 3'd1, 32'h03, 32'h1234);
        do_req(1'b0, 3'd3, 32'h08, 32'h0);
        do_req(1'b1, 3'd4, 32'h08, 32'h55);

        // Reset in the middle of an SB read-modify-write
        poke(32'h30, 32'hCAFEF00D);
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0; req_addr = 32'h31; req_wdata = 32'h77;
        we_snap = we_cycles;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("rmw_read_addr", mem_addr, 32'h30);
        @(negedge clk); rst = 1'b0;
        #1;
        check("abort_mem_we", {31'h0, mem_we}, 32'h0);
        check("abort_mem_addr", mem_addr, 32'h0);
        check("abort_mem_wd", mem_wd, 32'h0);
        check("abort_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        check("abort_ready", {31'h0, req_ready}, 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("abort_no_write", we_cycles - we_snap, 32'h0);
        check("abort_rsp_after", {31'h0, rsp_valid}, 32'h0);
        do_req(1'b0, 3'd2, 32'h30, 32'h0);

        // Randomized traffic
        for (int n = 0; n < 300; n++) begin
            do_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                   32'($urandom_range(0, 255)), $urandom);
        end

        for (int i = 0; i < 64; i++) check($sformatf("mem[%0d]", i), mem[i], ref_mem[i]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
